// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-to-one AXI4 read arbiter, one burst outstanding at a time
module axi_rd_arbiter #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter bit PRIO0          = 1'b0
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst,

    input  logic [AXI_ADDR_WIDTH-1:0] m0_araddr,
    input  logic [7:0]                m0_arlen,
    input  logic [2:0]                m0_arsize,
    input  logic [1:0]                m0_arburst,
    input  logic [3:0]                m0_arcache,
    input  logic                      m0_arvalid,
    output logic                      m0_arready,
    output logic                      m0_rvalid,
    input  logic                      m0_rready,
    output logic                      m0_rlast,
    output logic [AXI_DATA_WIDTH-1:0] m0_rdata,

    input  logic [AXI_ADDR_WIDTH-1:0] m1_araddr,
    input  logic [7:0]                m1_arlen,
    input  logic [2:0]                m1_arsize,
    input  logic [1:0]                m1_arburst,
    input  logic [3:0]                m1_arcache,
    input  logic                      m1_arvalid,
    output logic                      m1_arready,
    output logic                      m1_rvalid,
    input  logic                      m1_rready,
    output logic                      m1_rlast,
    output logic [AXI_DATA_WIDTH-1:0] m1_rdata,

    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic [3:0]                ARCACHE,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    input  logic                      RVALID,
    input  logic                      RLAST,
    input  logic [AXI_DATA_WIDTH-1:0] RDATA,
    output logic                      RREADY,

    output logic [1:0]                state,
    output logic                      grant,
    output logic                      beat_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        last_grant;
    logic [7:0]  arlen_q;
    logic [8:0]  beat_cnt;
    logic        any_req;
    logic        winner;
    logic        in_addr;
    logic        in_data;
    logic        r_hs;

    assign any_req = m0_arvalid || m1_arvalid;

    // last_grant resets to 1 so requester 0 wins the first round-robin tie
    assign winner = PRIO0 ? !m0_arvalid
                  : ((m0_arvalid && m1_arvalid) ? !last_grant : m1_arvalid);

    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);

    assign m0_arready = in_addr && !grant && ARREADY;
    assign m1_arready = in_addr &&  grant && ARREADY;

    assign RREADY     = in_data && (grant ? m1_rready : m0_rready);
    assign r_hs       = RVALID && RREADY;

    assign m0_rvalid  = in_data && !grant && RVALID;
    assign m1_rvalid  = in_data &&  grant && RVALID;
    assign m0_rlast   = in_data && !grant && RLAST;
    assign m1_rlast   = in_data &&  grant && RLAST;
    assign m0_rdata   = RDATA;
    assign m1_rdata   = RDATA;

    assign state      = state_q;

    always_ff @(posedge clk_100Mhz or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)               state_d = ADDR;
            ADDR:    if (ARVALID && ARREADY)    state_d = DATA;
            DATA:    if (r_hs && RLAST)         state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz or negedge rst) begin
        if (!rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            ARADDR     <= '0;
            ARLEN      <= '0;
            ARSIZE     <= '0;
            ARBURST    <= '0;
            ARCACHE    <= '0;
            ARVALID    <= 1'b0;
            arlen_q    <= '0;
            beat_cnt   <= '0;
            beat_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant   <= winner;
                        ARADDR  <= winner ? m1_araddr  : m0_araddr;
                        ARLEN   <= winner ? m1_arlen   : m0_arlen;
                        ARSIZE  <= winner ? m1_arsize  : m0_arsize;
                        ARBURST <= winner ? m1_arburst : m0_arburst;
                        ARCACHE <= winner ? m1_arcache : m0_arcache;
                        arlen_q <= winner ? m1_arlen   : m0_arlen;
                        ARVALID <= 1'b1;
                    end
                end
                ADDR: begin
                    if (ARVALID && ARREADY) begin
                        ARVALID  <= 1'b0;
                        beat_cnt <= '0;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        // beat_cnt still holds the count of earlier beats here
                        if (RLAST) begin
                            if (beat_cnt != {1'b0, arlen_q}) begin
                                beat_err <= 1'b1;
                            end
                            last_grant <= grant;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

    logic        clk_100Mhz = 1'b0;
    logic        rst;
    logic [31:0] m0_araddr, m1_araddr;
    logic [7:0]  m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize;
    logic [1:0]  m0_arburst, m1_arburst;
    logic [3:0]  m0_arcache, m1_arcache;
    logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
    logic        ARREADY, RVALID, RLAST;
    logic [63:0] RDATA;

    logic        m0_arready, m0_rvalid, m0_rlast, m1_arready, m1_rvalid, m1_rlast;
    logic [63:0] m0_rdata, m1_rdata;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARCACHE;
    logic        ARVALID, RREADY, grant, beat_err;
    logic [1:0]  state;

    logic        p_m0_arready, p_m0_rvalid, p_m0_rlast, p_m1_arready, p_m1_rvalid, p_m1_rlast;
    logic [63:0] p_m0_rdata, p_m1_rdata;
    logic [31:0] p_ARADDR;
    logic [7:0]  p_ARLEN;
    logic [2:0]  p_ARSIZE;
    logic [1:0]  p_ARBURST;
    logic [3:0]  p_ARCACHE;
    logic        p_ARVALID, p_RREADY, p_grant, p_beat_err;
    logic [1:0]  p_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int arv_cyc      = 0;
    int m0_arr_cyc   = 0;
    int m1_rv_cyc    = 0;
    int m0_beats     = 0;

    localparam logic [31:0] A0 = 32'h0100_0000;
    localparam logic [31:0] A1 = 32'h0300_0040;

    always #5 clk_100Mhz = ~clk_100Mhz;

    axi_rd_arbiter #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .PRIO0(1'b0)) dut (
        .clk_100Mhz(clk_100Mhz), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arcache(m0_arcache), .m0_arvalid(m0_arvalid),
        .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_rlast(m0_rlast), .m0_rdata(m0_rdata),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_arcache(m1_arcache), .m1_arvalid(m1_arvalid),
        .m1_arready(m1_arready), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_rlast(m1_rlast), .m1_rdata(m1_rdata),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARCACHE(ARCACHE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RVALID(RVALID), .RLAST(RLAST), .RDATA(RDATA), .RREADY(RREADY),
        .state(state), .grant(grant), .beat_err(beat_err)
    );

    axi_rd_arbiter #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .PRIO0(1'b1)) dut_prio (
        .clk_100Mhz(clk_100Mhz), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arcache(m0_arcache), .m0_arvalid(m0_arvalid),
        .m0_arready(p_m0_arready), .m0_rvalid(p_m0_rvalid), .m0_rready(m0_rready),
        .m0_rlast(p_m0_rlast), .m0_rdata(p_m0_rdata),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_arcache(m1_arcache), .m1_arvalid(m1_arvalid),
        .m1_arready(p_m1_arready), .m1_rvalid(p_m1_rvalid), .m1_rready(m1_rready),
        .m1_rlast(p_m1_rlast), .m1_rdata(p_m1_rdata),
        .ARADDR(p_ARADDR), .ARLEN(p_ARLEN), .ARSIZE(p_ARSIZE), .ARBURST(p_ARBURST),
        .ARCACHE(p_ARCACHE), .ARVALID(p_ARVALID), .ARREADY(ARREADY),
        .RVALID(RVALID), .RLAST(RLAST), .RDATA(RDATA), .RREADY(p_RREADY),
        .state(p_state), .grant(p_grant), .beat_err(p_beat_err)
    );

    always @(posedge clk_100Mhz) begin
        if (ARVALID)               arv_cyc    <= arv_cyc + 1;
        if (m0_arready)            m0_arr_cyc <= m0_arr_cyc + 1;
        if (m1_rvalid)             m1_rv_cyc  <= m1_rv_cyc + 1;
        if (m0_rvalid && m0_rready) m0_beats  <= m0_beats + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset;
        rst        = 1'b0;
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        RVALID     = 1'b0;
        RLAST      = 1'b0;
        ARREADY    = 1'b1;
        repeat (2) @(negedge clk_100Mhz);
        rst = 1'b1;
    endtask

    // Wait for the downstream AR to appear and check who won and what was forwarded
    task automatic wait_ar(input bit exp_g, input logic [31:0] exp_addr);
        int n;
        n = 0;
        do begin
            @(negedge clk_100Mhz);
            #1;
            n++;
        end while (!ARVALID && n < 20);
        check("ar_seen", 64'(ARVALID), 64'd1);
        check("grant", 64'(grant), 64'(exp_g));
        check("araddr", 64'(ARADDR), 64'(exp_addr));
        check("arcache", 64'(ARCACHE), exp_g ? 64'hF : 64'h3);
        check("arready_win", 64'(exp_g ? m1_arready : m0_arready), 64'(ARREADY));
        check("arready_other", 64'(exp_g ? m0_arready : m1_arready), 64'd0);
    endtask

    // Downstream R model: beat i carries 0xDA7A..i, RLAST on beat last_beat (1-based, 0 = never)
    task automatic serve(input int nbeats, input int last_beat, input bit who, input bit toggle);
        int          i;
        int          guard;
        bit          ph;
        logic [63:0] d;
        i = 0;
        guard = 0;
        ph = 1'b1;
        while (i < nbeats && guard < 500) begin
            @(negedge clk_100Mhz);
            guard++;
            if (toggle) begin
                m0_rready = ph;
                ph = !ph;
            end
            d      = 64'hDA7A_0000_0000_0000 | 64'(i);
            RVALID = 1'b1;
            RDATA  = d;
            RLAST  = (i == last_beat - 1);
            #1;
            if (RREADY) begin
                check("rvalid_win", 64'(who ? m1_rvalid : m0_rvalid), 64'd1);
                check("rvalid_other", 64'(who ? m0_rvalid : m1_rvalid), 64'd0);
                check("rlast_win", 64'(who ? m1_rlast : m0_rlast), 64'(i == last_beat - 1));
                check("rdata_m0", m0_rdata, d);
                check("rdata_m1", m1_rdata, d);
                i++;
            end else if (toggle && state == 2'd2) begin
                check("beat_cnt_hold", 64'(dut.beat_cnt), 64'(i));
            end
        end
        check("serve_beats", 64'(i), 64'(nbeats));
        @(negedge clk_100Mhz);
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        m0_rready = 1'b1;
        #1;
        if (last_beat != 0) check("idle_gap", 64'(state), 64'd0);
    endtask

    initial begin
        int b_arv, b_arr, b_rv, b_beats;
        m0_araddr = A0;  m0_arlen = 8'd3; m0_arsize = 3'd3; m0_arburst = 2'b01; m0_arcache = 4'h3;
        m1_araddr = A1;  m1_arlen = 8'd3; m1_arsize = 3'd2; m1_arburst = 2'b01; m1_arcache = 4'hF;
        m0_rready = 1'b1; m1_rready = 1'b1; RDATA = '0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; RVALID = 1'b0; RLAST = 1'b0; ARREADY = 1'b1;
        rst = 1'b0;

        // Reset values, with a request and read data present to prove IDLE gating
        m0_arvalid = 1'b1;
        RVALID     = 1'b1;
        #12;
        check("rst_state", 64'(state), 64'd0);
        check("rst_arvalid", 64'(ARVALID), 64'd0);
        check("rst_araddr", 64'(ARADDR), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_beat_err", 64'(beat_err), 64'd0);
        check("rst_rready", 64'(RREADY), 64'd0);
        check("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
        check("rst_m0_arready", 64'(m0_arready), 64'd0);

        // Round-robin and strict priority side by side: both requesters held
        do_reset();
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ar(k[0], k[0] ? A1 : A0);
            check("prio_grant0", 64'(p_grant), 64'd0);
            check("prio_araddr0", 64'(p_ARADDR), 64'(A0));
            serve(4, 4, k[0], 1'b0);
        end
        m0_arvalid = 1'b0;
        wait_ar(1'b1, A1);
        check("prio_grant1", 64'(p_grant), 64'd1);
        check("prio_araddr1", 64'(p_ARADDR), 64'(A1));
        m1_arvalid = 1'b0;
        serve(4, 4, 1'b1, 1'b0);

        // Single 64-beat burst with ARREADY tied high
        b_arv = arv_cyc; b_arr = m0_arr_cyc; b_rv = m1_rv_cyc; b_beats = m0_beats;
        m0_arlen   = 8'd63;
        m0_arvalid = 1'b1;
        wait_ar(1'b0, A0);
        check("t1_arlen", 64'(ARLEN), 64'd63);
        check("t1_arsize", 64'(ARSIZE), 64'd3);
        check("t1_arburst", 64'(ARBURST), 64'd1);
        m0_arvalid = 1'b0;
        serve(64, 64, 1'b0, 1'b0);
        check("t1_arvalid_cycles", 64'(arv_cyc - b_arv), 64'd1);
        check("t1_arready_pulses", 64'(m0_arr_cyc - b_arr), 64'd1);
        check("t1_m0_beats", 64'(m0_beats - b_beats), 64'd64);
        check("t1_m1_rvalid", 64'(m1_rv_cyc - b_rv), 64'd0);
        check("t1_beat_err", 64'(beat_err), 64'd0);

        // AR backpressure for 5 cycles, then alternating rready
        b_beats    = m0_beats;
        m0_araddr  = 32'h0200_0000;
        m0_arlen   = 8'd7;
        ARREADY    = 1'b0;
        m0_arvalid = 1'b1;
        wait_ar(1'b0, 32'h0200_0000);
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk_100Mhz);
            RVALID = 1'b1;
            #1;
            check("t4_arvalid_hold", 64'(ARVALID), 64'd1);
            check("t4_araddr_hold", 64'(ARADDR), 64'h0200_0000);
            check("t4_state_addr", 64'(state), 64'd1);
            check("t4_rready_addr", 64'(RREADY), 64'd0);
        end
        @(negedge clk_100Mhz);
        RVALID  = 1'b0;
        ARREADY = 1'b1;
        m1_arvalid = 1'b0;
        serve(8, 8, 1'b0, 1'b1);
        check("t4_m0_beats", 64'(m0_beats - b_beats), 64'd8);
        check("t4_beat_err", 64'(beat_err), 64'd0);

        // Short burst: RLAST on beat 32 of a 64-beat request
        m0_araddr  = A0;
        m0_arlen   = 8'd63;
        m0_arvalid = 1'b1;
        wait_ar(1'b0, A0);
        m0_arvalid = 1'b0;
        serve(32, 32, 1'b0, 1'b0);
        check("t5_beat_err_set", 64'(beat_err), 64'd1);
        m0_arlen   = 8'd3;
        m0_arvalid = 1'b1;
        wait_ar(1'b0, A0);
        m0_arvalid = 1'b0;
        serve(4, 4, 1'b0, 1'b0);
        check("t5_beat_err_sticky", 64'(beat_err), 64'd1);

        // Asynchronous reset in the middle of a burst
        m0_arlen   = 8'd63;
        m0_arvalid = 1'b1;
        wait_ar(1'b0, A0);
        m0_arvalid = 1'b0;
        serve(10, 0, 1'b0, 1'b0);
        RVALID = 1'b1;
        #1;
        check("t6_pre_rready", 64'(RREADY), 64'd1);
        rst = 1'b0;
        #1;
        check("t6_arvalid", 64'(ARVALID), 64'd0);
        check("t6_rready", 64'(RREADY), 64'd0);
        check("t6_m0_rvalid", 64'(m0_rvalid), 64'd0);
        check("t6_beat_err", 64'(beat_err), 64'd0);
        check("t6_state", 64'(state), 64'd0);
        @(negedge clk_100Mhz);
        RVALID = 1'b0;
        rst    = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
